// File: rtl/cache_pkg.sv
// Shared types and address-geometry helpers for the data cache and its storage array.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    RESP
  } state_e;

  localparam logic ADDR_WORD = 1'b0;
  localparam logic ADDR_BYTE = 1'b1;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int width, input int sets, input int line_words);
    return width - 2 - $clog2(sets) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Valid/tag/data storage for the direct-mapped data cache: combinational read,
// byte-enabled synchronous word write, line-valid set, async invalidate-all.
module data_cache_array
  import cache_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  localparam int OFF_W     = off_w(LINE_WORDS),
  localparam int IDX_W     = idx_w(SETS),
  localparam int TAG_W     = tag_w(WIDTH, SETS, LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [WIDTH-1:0] rd_word,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [3:0]       wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             set_valid,
  input  logic [TAG_W-1:0] set_tag
);

  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [WIDTH-1:0] data_mem [SETS*LINE_WORDS];

  always_comb begin
    valid_d = valid_q;
    if (set_valid) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data carry no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_mem[{wr_idx, wr_off}][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (set_valid) tag_mem[wr_idx] <= set_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_word  = data_mem[{rd_idx, rd_off}];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache with a handshaked memory port.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache
  import cache_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  localparam int OFF_W     = off_w(LINE_WORDS),
  localparam int IDX_W     = idx_w(SETS),
  localparam int TAG_W     = tag_w(WIDTH, SETS, LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] WD,
  input  logic             WE,
  input  logic             RE,
  input  logic             addr_mode,
  output logic [WIDTH-1:0] RD,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  state_e           state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;

  logic             rd_valid, hit, ack;
  logic [TAG_W-1:0] rd_tag;
  logic [WIDTH-1:0] rd_word, arr_wdata;
  logic             arr_we, arr_set_valid;
  logic [OFF_W-1:0] arr_off;
  logic [3:0]       arr_be;
  logic [7:0]       rd_byte;

  wire [OFF_W-1:0] a_off = A[2 +: OFF_W];
  wire [IDX_W-1:0] a_idx = A[2+OFF_W +: IDX_W];
  wire [TAG_W-1:0] a_tag = A[WIDTH-1 -: TAG_W];
  wire [OFF_W-1:0] q_off = mem_addr_q[2 +: OFF_W];
  wire [IDX_W-1:0] q_idx = mem_addr_q[2+OFF_W +: IDX_W];
  wire [TAG_W-1:0] q_tag = mem_addr_q[WIDTH-1 -: TAG_W];

  data_cache_array #(
    .WIDTH     (WIDTH),
    .SETS      (SETS),
    .LINE_WORDS(LINE_WORDS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (a_idx),
    .rd_off   (a_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word),
    .wr_en    (arr_we),
    .wr_idx   (q_idx),
    .wr_off   (arr_off),
    .wr_be    (arr_be),
    .wr_data  (arr_wdata),
    .set_valid(arr_set_valid),
    .set_tag  (q_tag)
  );

  assign hit = rd_valid && (rd_tag == a_tag);
  assign ack = mem_req_q && mem_ack;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    stall         = 1'b0;
    arr_we        = 1'b0;
    arr_be        = 4'b0000;
    arr_off       = q_off;
    arr_wdata     = mem_rdata;
    arr_set_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (WE) begin
          stall      = 1'b1;
          state_d    = WRITE;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = {A[WIDTH-1:2], 2'b00};
          if (addr_mode == ADDR_BYTE) begin
            mem_be_d    = 4'b0001 << A[1:0];
            mem_wdata_d = {4{WD[7:0]}};
          end else begin
            mem_be_d    = 4'b1111;
            mem_wdata_d = WD;
          end
        end else if (RE && !hit) begin
          stall      = 1'b1;
          state_d    = REFILL;
          beat_d     = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {a_tag, a_idx, {OFF_W{1'b0}}, 2'b00};
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (ack) begin
          arr_we  = 1'b1;
          arr_be  = 4'b1111;
          arr_off = beat_q;
          beat_d  = beat_q + 1'b1;
          if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
            arr_set_valid = 1'b1;
            mem_req_d     = 1'b0;
            state_d       = RESP;
          end else begin
            mem_addr_d = {q_tag, q_idx, beat_d, 2'b00};
          end
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (ack) begin
          // Write-through: refresh the cached copy only if the line is resident.
          arr_we    = hit;
          arr_be    = mem_be_q;
          arr_wdata = mem_wdata_q;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  assign rd_byte = rd_word[{A[1:0], 3'b000} +: 8];

  always_comb begin
    RD = '0;
    if (RE) RD = (addr_mode == ADDR_BYTE) ? WIDTH'(rd_byte) : rd_word;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && !WE && RE) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
